// File: rtl/fetch_redirect_ctrl.sv
// fetch_redirect_ctrl: arbitrates decode/execute redirect requests and
// load-use stalls into one-hot fetch commands, flush strobes and
// saturating event counters. A one-cycle squash shadow follows every
// redirect so that wrong-path requests behind it are ignored.
//
// Interface semantics: the *_valid inputs qualify their stage's fields in
// the same cycle. There is no back-pressure on this block. Every command
// output is a single-cycle strobe that the fetch unit consumes
// unconditionally in the cycle it is high.
module fetch_redirect_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic             id_is_jal,
  input  logic [XLEN-1:0]  id_UJimm,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic             ex_br_taken,
  input  logic             ex_is_jalr,
  input  logic [XLEN-1:0]  ex_jalr_target,
  input  logic [XLEN-1:0]  ex_SBimm,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_rd,
  output logic             b_en,
  output logic             UJ_en,
  output logic             jalr,
  output logic             stall,
  output logic [XLEN-1:0]  al,
  output logic [XLEN-1:0]  UJimm,
  output logic [XLEN-1:0]  SBimm,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    SHADOW_EX = 2'd1,
    SHADOW_ID = 2'd2
  } state_t;

  state_t state, state_next;
  logic   ev, dv, load_use;

  assign state_dbg = state;

  // Arbitration by program age: execute is older than decode, so its
  // redirects win; a load-use stall outranks the younger decode JAL.
  always_comb begin
    b_en       = 1'b0;
    UJ_en      = 1'b0;
    jalr       = 1'b0;
    stall      = 1'b0;
    al         = '0;
    UJimm      = '0;
    SBimm      = '0;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    state_next = RUN;

    // Shadow after an execute redirect kills both younger stages;
    // shadow after a decode redirect kills only the decode slot.
    ev = ex_valid & (state != SHADOW_EX);
    dv = id_valid & (state == RUN);

    load_use = ev & ex_is_load & (ex_rd != 5'd0) & dv &
               ((id_use_rs1 & (id_rs1 == ex_rd)) |
                (id_use_rs2 & (id_rs2 == ex_rd)));

    if (reset) begin
      state_next = RUN;
    end else if (ev & ex_is_jalr) begin
      jalr       = 1'b1;
      al         = ex_jalr_target;
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
      state_next = SHADOW_EX;
    end else if (ev & ex_is_branch & ex_br_taken) begin
      b_en       = 1'b1;
      SBimm      = ex_SBimm;
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
      state_next = SHADOW_EX;
    end else if (load_use) begin
      stall      = 1'b1;
      flush_idex = 1'b1;
      state_next = RUN;
    end else if (dv & id_is_jal) begin
      UJ_en      = 1'b1;
      UJimm      = id_UJimm;
      flush_ifid = 1'b1;
      state_next = SHADOW_ID;
    end
  end

  // State register; reset aborts any shadow in progress.
  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  // Saturating event counters, held at all-ones once reached.
  always_ff @(posedge clk) begin
    if (reset) begin
      redirect_cnt <= '0;
      stall_cnt    <= '0;
    end else begin
      if ((jalr | b_en | UJ_en) && (redirect_cnt != {CNT_W{1'b1}}))
        redirect_cnt <= redirect_cnt + 1'b1;
      if (stall && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Testbench for fetch_redirect_ctrl: directed scenarios plus a randomized
// run checked against a rule-level reference model.
module tb_fetch_redirect_ctrl;

  localparam int XLEN = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic            id_valid, id_is_jal, id_use_rs1, id_use_rs2;
  logic [XLEN-1:0] id_UJimm;
  logic [4:0]      id_rs1, id_rs2;
  logic            ex_valid, ex_is_branch, ex_br_taken, ex_is_jalr, ex_is_load;
  logic [XLEN-1:0] ex_jalr_target, ex_SBimm;
  logic [4:0]      ex_rd;

  logic            b_en, UJ_en, jalr, stall, flush_ifid, flush_idex;
  logic [XLEN-1:0] al, UJimm, SBimm;
  logic [15:0]     redirect_cnt, stall_cnt;
  logic [1:0]      state_dbg;

  logic            b_en4, UJ_en4, jalr4, stall4, flush_ifid4, flush_idex4;
  logic [XLEN-1:0] al4, UJimm4, SBimm4;
  logic [3:0]      redirect_cnt4, stall_cnt4;
  logic [1:0]      state_dbg4;

  logic [5:0] got_cmd;
  assign got_cmd = {jalr, UJ_en, b_en, stall, flush_ifid, flush_idex};

  fetch_redirect_ctrl #(.XLEN(XLEN), .CNT_W(16)) dut (
    .clk(clk), .reset(rst),
    .id_valid(id_valid), .id_is_jal(id_is_jal), .id_UJimm(id_UJimm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_br_taken(ex_br_taken),
    .ex_is_jalr(ex_is_jalr), .ex_jalr_target(ex_jalr_target), .ex_SBimm(ex_SBimm),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .b_en(b_en), .UJ_en(UJ_en), .jalr(jalr), .stall(stall),
    .al(al), .UJimm(UJimm), .SBimm(SBimm),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .redirect_cnt(redirect_cnt), .stall_cnt(stall_cnt), .state_dbg(state_dbg)
  );

  fetch_redirect_ctrl #(.XLEN(XLEN), .CNT_W(4)) dut4 (
    .clk(clk), .reset(rst),
    .id_valid(id_valid), .id_is_jal(id_is_jal), .id_UJimm(id_UJimm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_br_taken(ex_br_taken),
    .ex_is_jalr(ex_is_jalr), .ex_jalr_target(ex_jalr_target), .ex_SBimm(ex_SBimm),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .b_en(b_en4), .UJ_en(UJ_en4), .jalr(jalr4), .stall(stall4),
    .al(al4), .UJimm(UJimm4), .SBimm(SBimm4),
    .flush_ifid(flush_ifid4), .flush_idex(flush_idex4),
    .redirect_cnt(redirect_cnt4), .stall_cnt(stall_cnt4), .state_dbg(state_dbg4)
  );

  // ---------------- reference model ----------------
  // prev_kind records what the previous cycle did: 0 nothing, 1 an execute
  // redirect (kills both younger stages), 2 a decode redirect (kills decode).
  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  int          prev_kind = 0;
  int unsigned m_redir = 0, m_stall = 0, m_redir4 = 0, m_stall4 = 0;

  logic [5:0]      exp_cmd;
  logic [XLEN-1:0] exp_al, exp_ujimm, exp_sbimm;

  function automatic void model_eval();
    bit ev, dv, haz;
    exp_cmd   = 6'b0;
    exp_al    = '0;
    exp_ujimm = '0;
    exp_sbimm = '0;
    ev  = ex_valid && (prev_kind != 1);
    dv  = id_valid && (prev_kind == 0);
    haz = ev && ex_is_load && (ex_rd != 0) && dv &&
          ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    if (rst) begin
      exp_cmd = 6'b0;
    end else if (ev && ex_is_jalr) begin
      exp_cmd = 6'b100011; exp_al = ex_jalr_target;
    end else if (ev && ex_is_branch && ex_br_taken) begin
      exp_cmd = 6'b001011; exp_sbimm = ex_SBimm;
    end else if (haz) begin
      exp_cmd = 6'b000101;
    end else if (dv && id_is_jal) begin
      exp_cmd = 6'b010010; exp_ujimm = id_UJimm;
    end
  endfunction

  // Advance one clock: evaluate the model on the current inputs, update
  // model history at the edge, and return at the following falling edge.
  task automatic advance();
    model_eval();
    @(posedge clk);
    if (rst) begin
      prev_kind = 0;
      m_redir = 0; m_stall = 0; m_redir4 = 0; m_stall4 = 0;
    end else begin
      if (exp_cmd[5] || exp_cmd[3]) prev_kind = 1;
      else if (exp_cmd[4])          prev_kind = 2;
      else                          prev_kind = 0;
      if (exp_cmd[5] || exp_cmd[4] || exp_cmd[3]) begin
        if (m_redir  < 65535) m_redir++;
        if (m_redir4 < 15)    m_redir4++;
      end
      if (exp_cmd[2]) begin
        if (m_stall  < 65535) m_stall++;
        if (m_stall4 < 15)    m_stall4++;
      end
    end
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    id_valid = 0; id_is_jal = 0; id_UJimm = '0; id_rs1 = 0; id_rs2 = 0;
    id_use_rs1 = 0; id_use_rs2 = 0;
    ex_valid = 0; ex_is_branch = 0; ex_br_taken = 0; ex_is_jalr = 0;
    ex_jalr_target = '0; ex_SBimm = '0; ex_is_load = 0; ex_rd = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    set_idle();
    rst = 1;
    ex_valid = 1; ex_is_jalr = 1; ex_jalr_target = 32'h0000_1234;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_total++;
      if (got_cmd !== 6'b0)
        $display("FAIL reset_cmds cyc%0d: got %b want 000000", i, got_cmd);
      else n_pass++;
      advance();
      n_total++;
      if (state_dbg !== 2'd0 || redirect_cnt !== 16'd0 || stall_cnt !== 16'd0)
        $display("FAIL reset_state: state %0d rcnt %0d scnt %0d want 0 0 0",
                 state_dbg, redirect_cnt, stall_cnt);
      else n_pass++;
    end
    rst = 0;
    #1;
    n_total++;
    if (got_cmd !== 6'b100011 || al !== 32'h0000_1234)
      $display("FAIL reset_release: cmd %b al %h want 100011 00001234", got_cmd, al);
    else n_pass++;
    advance();
    set_idle();
    advance();
  endtask

  task automatic test_branch_vs_jal();
    set_idle();
    ex_valid = 1; ex_is_branch = 1; ex_br_taken = 1; ex_SBimm = 32'h40;
    id_valid = 1; id_is_jal = 1; id_UJimm = 32'h100;
    #1;
    n_total++;
    if (got_cmd !== 6'b001011 || SBimm !== 32'h40 || UJimm !== 32'h0)
      $display("FAIL branch_wins: cmd %b sb %h uj %h want 001011 40 0", got_cmd, SBimm, UJimm);
    else n_pass++;
    advance();
    ex_is_branch = 0; ex_br_taken = 0; ex_SBimm = '0;
    #1;
    n_total++;
    if (got_cmd !== 6'b0 || UJimm !== 32'h0)
      $display("FAIL shadow_ex_suppress: cmd %b uj %h want 000000 0", got_cmd, UJimm);
    else n_pass++;
    advance();
    #1;
    n_total++;
    if (got_cmd !== 6'b010010 || UJimm !== 32'h100)
      $display("FAIL jal_after_shadow: cmd %b uj %h want 010010 100", got_cmd, UJimm);
    else n_pass++;
    advance();
    set_idle();
    advance();
  endtask

  task automatic test_load_use();
    set_idle();
    ex_valid = 1; ex_is_load = 1; ex_rd = 5;
    id_valid = 1; id_rs2 = 5; id_use_rs2 = 1; id_rs1 = 7; id_is_jal = 1; id_UJimm = 32'h80;
    #1;
    n_total++;
    if (got_cmd !== 6'b000101 || UJimm !== 32'h0)
      $display("FAIL load_use_stall: cmd %b uj %h want 000101 0", got_cmd, UJimm);
    else n_pass++;
    advance();
    n_total++;
    if (stall_cnt !== 16'd1)
      $display("FAIL stall_cnt: got %0d want 1", stall_cnt);
    else n_pass++;
    ex_rd = 0; id_rs2 = 0;
    #1;
    n_total++;
    if (got_cmd !== 6'b010010 || UJimm !== 32'h80)
      $display("FAIL rd0_no_stall: cmd %b uj %h want 010010 80", got_cmd, UJimm);
    else n_pass++;
    advance();
    set_idle();
    advance();
  endtask

  task automatic test_back_to_back();
    set_idle();
    id_valid = 1; id_is_jal = 1; id_UJimm = 32'h20;
    #1;
    n_total++;
    if (got_cmd !== 6'b010010 || UJimm !== 32'h20)
      $display("FAIL b2b_jal: cmd %b uj %h want 010010 20", got_cmd, UJimm);
    else n_pass++;
    advance();
    set_idle();
    ex_valid = 1; ex_is_jalr = 1; ex_jalr_target = 32'h2000;
    #1;
    n_total++;
    if (got_cmd !== 6'b100011 || al !== 32'h2000)
      $display("FAIL b2b_jalr_in_shadow_id: cmd %b al %h want 100011 2000", got_cmd, al);
    else n_pass++;
    advance();
    set_idle();
    advance();
  endtask

  task automatic test_saturation();
    set_idle();
    rst = 1;
    advance();
    rst = 0;
    for (int i = 0; i < 20; i++) begin
      id_valid = 1; id_is_jal = 1; id_UJimm = 32'(i * 4);
      advance();
      set_idle();
      advance();
    end
    n_total++;
    if (redirect_cnt4 !== 4'd15)
      $display("FAIL sat_cnt4: got %0d want 15", redirect_cnt4);
    else n_pass++;
    n_total++;
    if (redirect_cnt !== 16'd20)
      $display("FAIL cnt16_after_20: got %0d want 20", redirect_cnt);
    else n_pass++;
  endtask

  task automatic test_random();
    int unsigned bad = 0;
    for (int c = 0; c < 10000; c++) begin
      rst          = ($urandom_range(0, 299) == 0);
      id_valid     = ($urandom_range(0, 3) != 0);
      id_is_jal    = ($urandom_range(0, 3) == 0);
      id_UJimm     = $urandom;
      id_rs1       = 5'($urandom_range(0, 3));
      id_rs2       = 5'($urandom_range(0, 3));
      id_use_rs1   = $urandom_range(0, 1);
      id_use_rs2   = $urandom_range(0, 1);
      ex_valid     = ($urandom_range(0, 3) != 0);
      ex_is_branch = ($urandom_range(0, 2) == 0);
      ex_br_taken  = $urandom_range(0, 1);
      ex_is_jalr   = ($urandom_range(0, 7) == 0);
      ex_jalr_target = $urandom & 32'hFFFF_FFFE;
      ex_SBimm     = $urandom;
      ex_is_load   = ($urandom_range(0, 2) == 0);
      ex_rd        = 5'($urandom_range(0, 3));
      #1;
      model_eval();
      n_total++;
      if ($countones({jalr, UJ_en, b_en, stall}) > 1)
        $display("FAIL rand_onehot cyc%0d: cmds %b", c, got_cmd[5:2]);
      else n_pass++;
      n_total++;
      if ((!jalr && al !== '0) || (!UJ_en && UJimm !== '0) || (!b_en && SBimm !== '0))
        $display("FAIL rand_operand_zero cyc%0d: al %h uj %h sb %h", c, al, UJimm, SBimm);
      else n_pass++;
      n_total++;
      if (got_cmd !== exp_cmd || al !== exp_al || UJimm !== exp_ujimm || SBimm !== exp_sbimm) begin
        if (bad < 10)
          $display("FAIL rand_outputs cyc%0d: cmd %b al %h uj %h sb %h want %b %h %h %h",
                   c, got_cmd, al, UJimm, SBimm, exp_cmd, exp_al, exp_ujimm, exp_sbimm);
        bad++;
      end else n_pass++;
      advance();
      n_total++;
      if (redirect_cnt !== 16'(m_redir) || stall_cnt !== 16'(m_stall) ||
          redirect_cnt4 !== 4'(m_redir4) || stall_cnt4 !== 4'(m_stall4)) begin
        if (bad < 10)
          $display("FAIL rand_counters cyc%0d: %0d %0d %0d %0d want %0d %0d %0d %0d", c,
                   redirect_cnt, stall_cnt, redirect_cnt4, stall_cnt4,
                   m_redir, m_stall, m_redir4, m_stall4);
        bad++;
      end else n_pass++;
    end
    rst = 0;
    set_idle();
    advance();
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    set_idle();
    rst = 1;
    @(negedge clk);
    test_reset();
    test_branch_vs_jal();
    test_load_use();
    test_back_to_back();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_redirect_ctrl.md
Name: fetch_redirect_ctrl

Overview:
- Control-side partner of the fetch unit: the block that drives its redirect/stall command interface.
- Collects redirect sources from decode (JAL) and execute (taken branch, JALR) and load-use hazards.
- Arbitrates them by program age and suppresses wrong-path requests during a squash shadow.
- Emits one-hot fetch commands, pipeline flush strobes and saturating event counters.

Parameters:
- XLEN, 32, data/address width.
- CNT_W, 16, width of the redirect and stall event counters.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- id_valid  in  1  decode-stage instruction valid
- id_is_jal  in  1  decode instruction is JAL
- id_UJimm  in  XLEN  JAL offset from decode
- id_rs1, id_rs2  in  5 each  decode source registers
- id_use_rs1, id_use_rs2  in  1 each  source register is actually read
- ex_valid  in  1  execute-stage instruction valid
- ex_is_branch  in  1  execute instruction is a conditional branch
- ex_br_taken  in  1  branch condition true
- ex_is_jalr  in  1  execute instruction is JALR
- ex_jalr_target  in  XLEN  JALR target, bit 0 already cleared
- ex_SBimm  in  XLEN  branch offset
- ex_is_load  in  1  execute instruction is a load
- ex_rd  in  5  execute destination register
- b_en, UJ_en, jalr, stall  out  1 each  one-hot fetch commands
- al, UJimm, SBimm  out  XLEN each  fetch target/offset operands
- flush_ifid, flush_idex  out  1 each  bubble-insert strobes
- redirect_cnt, stall_cnt  out  CNT_W each  saturating event counts

Behaviour:
- Commands and flushes are combinational from the inputs and the registered state. Counters and state are registered.
- At most one of jalr, UJ_en, b_en, stall is high in any cycle. This is a hard invariant.
- States:
  - RUN: normal operation.
  - SHADOW_EX: one cycle after an execute redirect.
  - SHADOW_ID: one cycle after a decode redirect.
- Effective valids:
  - ev = ex_valid, except forced 0 in SHADOW_EX.
  - dv = id_valid, except forced 0 in SHADOW_EX or SHADOW_ID.
- Priority, oldest first:
  1. ev & ex_is_jalr: jalr=1, al=ex_jalr_target, flush_ifid=1, flush_idex=1; next state SHADOW_EX.
  2. ev & ex_is_branch & ex_br_taken: b_en=1, SBimm=ex_SBimm, both flushes=1; next state SHADOW_EX.
  3. Load-use hazard: ev & ex_is_load & ex_rd!=0 & dv & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)). Response: stall=1, flush_idex=1, decode JAL ignored this cycle; state stays RUN.
  4. dv & id_is_jal: UJ_en=1, UJimm=id_UJimm, flush_ifid=1; next state SHADOW_ID.
  5. Otherwise all commands 0; next state RUN.
- Shadow states last exactly one cycle, then return to RUN unless a new non-suppressed redirect fires.
  - In SHADOW_ID, execute requests are honoured (ev not suppressed) and may re-enter SHADOW_EX.
- Operand outputs: al, UJimm, SBimm are 0 whenever their enable is 0. No stale values are driven.
- Counters:
  - redirect_cnt increments on any of jalr, b_en, UJ_en.
  - stall_cnt increments on stall.
  - Both saturate at 2^CNT_W-1 with no wrap.
- Reset:
  - State becomes RUN; counters become 0.
  - All command and flush outputs are forced 0 during the reset cycle regardless of inputs.
  - Reset asserted mid-shadow aborts the shadow.
- ex_rd==0 never stalls. A not-taken branch produces no output and no state change.

Test Plan:
- Reset held 2 cycles with ex_is_jalr=1, ex_valid=1 -> all commands/flushes 0; state RUN, counters 0. Release -> jalr=1, al=ex_jalr_target.
- ex branch taken with SBimm=0x40, and the same cycle id_is_jal with UJimm=0x100 -> only b_en=1, SBimm=0x40, UJimm=0. Next cycle id_is_jal=1, ex_is_branch=0 -> UJ_en=0 (shadow); third cycle -> UJ_en=1.
- ex load rd=5, id rs2=5 with use_rs2=1, id_is_jal=1 -> stall=1, flush_idex=1, UJ_en=0, stall_cnt=1. Same stimulus with rd=0 -> no stall, UJ_en=1.
- id JAL (UJimm=0x20), next cycle ex_is_jalr=1 target 0x2000 -> cycle 1: UJ_en=1, flush_ifid=1. Cycle 2: jalr=1, al=0x2000, both flushes=1.
- CNT_W=4 with 20 consecutive JAL redirects on alternating cycles -> redirect_cnt stops at 15.
- Random 10k-cycle stimulus -> one-hot invariant never violated; operand outputs 0 whenever their enable is 0.
